// File: rtl/rpn_stack_ctrl.sv
// RPN stack controller: cached TOS register, lower entries in an external synchronous RAM.
// Optional macro RPN_MUL_EN enables opcode 110 as an 8-bit MUL; otherwise 110 raises err_op.
module rpn_stack_ctrl #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [2:0]        op_code,
    input  logic [7:0]        op_data,
    output logic              op_ready,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        tos,
    output logic [ADDR_W:0]   depth,
    output logic              err_ovf,
    output logic              err_unf,
    output logic              err_op
);

    localparam int unsigned DW  = ADDR_W + 1;
    localparam int unsigned CAP = 1 << ADDR_W;

`ifdef RPN_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic [1:0] {IDLE, WR, RD, EXEC} state_t;

    state_t            state_q, state_d;
    logic [7:0]        tos_q, tos_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic [2:0]        opc_q, opc_d;
    logic [7:0]        data_q, data_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wren_q, wren_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              eop_q, eop_d;
    logic [ADDR_W-1:0] sp_c;
    logic [7:0]        alu_c;

    assign sp_c = (depth_q == '0) ? '0 : ADDR_W'(depth_q - DW'(1));

    // EXEC result: NOS (arriving on ram_rdata) combined with TOS; POP just takes NOS
    always_comb begin
        alu_c = ram_rdata;
        case (opc_q)
            OP_ADD:  alu_c = ram_rdata + tos_q;
            OP_SUB:  alu_c = ram_rdata - tos_q;
            OP_AND:  alu_c = ram_rdata & tos_q;
            OP_OR:   alu_c = ram_rdata | tos_q;
`ifdef RPN_MUL_EN
            OP_MUL:  alu_c = 8'(ram_rdata * tos_q);
`endif
            default: alu_c = ram_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tos_d   = tos_q;
        depth_d = depth_q;
        opc_d   = opc_q;
        data_d  = data_q;
        done_d  = 1'b0;
        addr_d  = '0;
        wren_d  = 1'b0;
        wdata_d = '0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        eop_d   = eop_q;

        case (state_q)
            IDLE: begin
                if (op_valid && ready_q) begin
                    opc_d = op_code;
                    data_d = op_data;
                    case (op_code)
                        OP_PUSH: begin
                            if (depth_q == '0) begin
                                tos_d   = op_data;
                                depth_d = DW'(1);
                                done_d  = 1'b1;
                            end else if (depth_q == DW'(CAP)) begin
                                ovf_d  = 1'b1;
                                done_d = 1'b1;
                            end else begin
                                state_d = WR;
                                addr_d  = sp_c;
                                wren_d  = 1'b1;
                                wdata_d = tos_q;
                            end
                        end
                        OP_CLR: begin
                            tos_d   = '0;
                            depth_d = '0;
                            done_d  = 1'b1;
                        end
                        default: begin
                            // POP and the binary ops share the NOS read path
                            if (op_code == OP_MUL && !MUL_EN) begin
                                eop_d  = 1'b1;
                                done_d = 1'b1;
                            end else if (op_code == OP_POP && depth_q == DW'(1)) begin
                                tos_d   = '0;
                                depth_d = '0;
                                done_d  = 1'b1;
                            end else if (depth_q < DW'(2)) begin
                                unf_d  = 1'b1;
                                done_d = 1'b1;
                            end else begin
                                state_d = RD;
                                addr_d  = sp_c - ADDR_W'(1);
                            end
                        end
                    endcase
                end
            end
            WR: begin
                state_d = IDLE;
                tos_d   = data_q;
                depth_d = depth_q + DW'(1);
                done_d  = 1'b1;
            end
            RD: begin
                state_d = EXEC;
            end
            EXEC: begin
                state_d = IDLE;
                tos_d   = alu_c;
                depth_d = depth_q - DW'(1);
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            tos_q   <= '0;
            depth_q <= '0;
            opc_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            addr_q  <= '0;
            wren_q  <= 1'b0;
            wdata_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tos_q   <= tos_d;
            depth_q <= depth_d;
            opc_q   <= opc_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            wren_q  <= wren_d;
            wdata_q <= wdata_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            eop_q   <= eop_d;
        end
    end

    assign op_ready  = ready_q;
    assign done      = done_q;
    assign ram_addr  = addr_q;
    assign ram_wren  = wren_q;
    assign ram_wdata = wdata_q;
    assign tos       = tos_q;
    assign depth     = depth_q;
    assign err_ovf   = ovf_q;
    assign err_unf   = unf_q;
    assign err_op    = eop_q;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl (ADDR_W=2): directed scenarios plus random ops against a queue-based stack model.
module tb_rpn_stack_ctrl;

    localparam int AW  = 2;
    localparam int CAP = 1 << AW;

    logic          CLOCK_50 = 1'b0;
    logic          reset = 1'b1;
    logic          op_valid = 1'b0;
    logic [2:0]    op_code = '0;
    logic [7:0]    op_data = '0;
    logic          op_ready, done, ram_wren, err_ovf, err_unf, err_op;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata, tos;
    logic [7:0]    ram_rdata = '0;
    logic [AW:0]   depth;

    logic [7:0] mem [CAP];

    int checks = 0;
    int errors = 0;
    int wr_total = 0;
    int idle_viol = 0;
    int wr_addr = 0;
    int wr_data = 0;

    // model state
    int m_stk[$];
    bit m_ovf, m_unf, m_op;

    rpn_stack_ctrl #(.ADDR_W(AW)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .op_valid (op_valid),
        .op_code  (op_code),
        .op_data  (op_data),
        .op_ready (op_ready),
        .done     (done),
        .ram_addr (ram_addr),
        .ram_wren (ram_wren),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .tos      (tos),
        .depth    (depth),
        .err_ovf  (err_ovf),
        .err_unf  (err_unf),
        .err_op   (err_op)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // synchronous RAM, one-cycle read latency
    always @(posedge CLOCK_50) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    always @(negedge CLOCK_50) begin
        if (ram_wren) begin
            wr_total++;
            wr_addr = int'(ram_addr);
            wr_data = int'(ram_wdata);
        end
        if (op_ready && (ram_addr != '0 || ram_wren)) idle_viol++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int m_tos();
        return (m_stk.size() == 0) ? 0 : m_stk[m_stk.size()-1];
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_tos"}, int'(tos), m_tos());
        check({tag, "_depth"}, int'(depth), m_stk.size());
        check({tag, "_ovf"}, int'(err_ovf), int'(m_ovf));
        check({tag, "_unf"}, int'(err_unf), int'(m_unf));
        check({tag, "_eop"}, int'(err_op), int'(m_op));
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        op_valid = 1'b0;
        @(negedge CLOCK_50);
        reset = 1'b0;
        m_stk.delete();
        m_ovf = 0; m_unf = 0; m_op = 0;
        @(negedge CLOCK_50);
        check("rst_ready", int'(op_ready), 1);
        check("rst_done", int'(done), 0);
        check_state("rst");
    endtask

    task automatic do_op(input logic [2:0] opc, input logic [7:0] d);
        int n, exp_lat, exp_wr, exp_addr, exp_data, wr0, a, b, r;
        bit binary;
        n = 0;
        while (!op_ready && n < 20) begin @(negedge CLOCK_50); n++; end
        check("op_ready", int'(op_ready), 1);

        exp_lat = 0; exp_wr = 0; exp_addr = 0; exp_data = 0;
        binary = (opc >= 3'd2 && opc <= 3'd6);
`ifndef RPN_MUL_EN
        if (opc == 3'd6) binary = 0;
`endif
        if (opc == 3'd0) begin
            if (m_stk.size() == CAP) m_ovf = 1;
            else begin
                if (m_stk.size() > 0) begin
                    exp_wr = 1; exp_addr = m_stk.size() - 1; exp_data = m_tos(); exp_lat = 1;
                end
                m_stk.push_back(int'(d));
            end
        end else if (opc == 3'd7) begin
            m_stk.delete();
        end else if (opc == 3'd1) begin
            if (m_stk.size() == 0) m_unf = 1;
            else begin
                if (m_stk.size() >= 2) exp_lat = 2;
                void'(m_stk.pop_back());
            end
        end else if (binary) begin
            if (m_stk.size() < 2) m_unf = 1;
            else begin
                a = m_stk.pop_back();
                b = m_stk.pop_back();
                case (opc)
                    3'd2: r = b + a;
                    3'd3: r = b - a;
                    3'd4: r = b & a;
                    3'd5: r = b | a;
                    default: r = b * a;
                endcase
                m_stk.push_back(r & 255);
                exp_lat = 2;
            end
        end else begin
            m_op = 1;
        end

        wr0 = wr_total;
        op_valid = 1'b1; op_code = opc; op_data = d;
        @(negedge CLOCK_50);
        n = 0;
        while (1) begin
            op_valid = op_ready ? 1'b0 : 1'($urandom);
            op_code = 3'($urandom);
            op_data = 8'($urandom);
            if (done || n >= 10) break;
            @(negedge CLOCK_50);
            n++;
        end
        check("done", int'(done), 1);
        check("latency", n, exp_lat);
        check("wr_cycles", wr_total - wr0, exp_wr);
        if (exp_wr != 0) begin
            check("wr_addr", wr_addr, exp_addr);
            check("wr_data", wr_data, exp_data);
        end
        check_state("op");
        @(negedge CLOCK_50);
        check("done_pulse", int'(done), 0);
        op_valid = 1'b0;
    endtask

    initial begin
        int n;
        m_ovf = 0; m_unf = 0; m_op = 0;
        do_reset();

        // PUSH 5, PUSH 7, ADD
        do_op(3'd0, 8'd5); do_op(3'd0, 8'd7);
        check("add_wraddr", wr_addr, 0);
        check("add_wrdata", wr_data, 5);
        do_op(3'd2, 8'd0);
        check("add_tos", int'(tos), 12);
        check("add_depth", int'(depth), 1);

        // PUSH 3, PUSH 10, SUB -> 249
        do_reset();
        do_op(3'd0, 8'd3); do_op(3'd0, 8'd10); do_op(3'd3, 8'd0);
        check("sub_tos", int'(tos), 249);

        // underflow is sticky
        do_reset();
        do_op(3'd1, 8'd0);
        check("unf_flag", int'(err_unf), 1);
        do_op(3'd0, 8'd1); do_op(3'd2, 8'd0);
        check("unf_sticky", int'(err_unf), 1);
        check("unf_tos", int'(tos), 1);

        // overflow at capacity, then drain
        do_reset();
        for (int i = 1; i <= 5; i++) do_op(3'd0, 8'(i));
        check("ovf_flag", int'(err_ovf), 1);
        check("ovf_depth", int'(depth), CAP);
        for (int i = 3; i >= 1; i--) begin
            do_op(3'd1, 8'd0);
            check("drain_tos", int'(tos), i);
        end

        // opcode 110
        do_reset();
        do_op(3'd0, 8'd20); do_op(3'd0, 8'd13); do_op(3'd6, 8'd0);
`ifdef RPN_MUL_EN
        check("mul_tos", int'(tos), 4);
`else
        check("mul_eop", int'(err_op), 1);
        check("mul_depth", int'(depth), 2);
`endif

        // reset while a POP at depth 3 sits in RD
        do_reset();
        do_op(3'd0, 8'd1); do_op(3'd0, 8'd2); do_op(3'd0, 8'd3);
        op_valid = 1'b1; op_code = 3'd1;
        @(negedge CLOCK_50);
        op_valid = 1'b0;
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        m_stk.delete(); m_ovf = 0; m_unf = 0; m_op = 0;
        check("midrst_depth", int'(depth), 0);
        check("midrst_tos", int'(tos), 0);
        check("midrst_ready", int'(op_ready), 1);
        check("midrst_done", int'(done), 0);
        n = 0;
        for (int i = 0; i < 4; i++) begin @(negedge CLOCK_50); n += int'(done); end
        check("midrst_nodone", n, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [2:0] opc;
            opc = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) opc = 3'd0;
            if ($urandom_range(0, 60) == 0) do_reset();
            do_op(opc, 8'($urandom));
        end

        check("idle_addr_viol", idle_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
